// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: a programmable modulo counter built from a bank of WIDTH
// toggle cells. Each cycle the controller derives a toggle vector from the
// count, the direction and the loaded limit, and applies it to the cells.
// Commands (START/STOP/LOAD/ONESHOT) arrive over a valid/ready handshake.
// tc pulses after a free-run wrap, and done pulses after a one-shot completes.
// Optional feature macro: TFF_CTRL_ONESHOT_EN enables the ONESHOT op and the
// ONE state. Without it, op 11 is accepted and ignored, and done stays 0.
module tff_count_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
`ifdef TFF_CTRL_ONESHOT_EN
  localparam logic [1:0] ST_ONE  = 2'd3;
`endif

  localparam logic [1:0] OP_START   = 2'b00;
  localparam logic [1:0] OP_STOP    = 2'b01;
  localparam logic [1:0] OP_LOAD    = 2'b10;
  localparam logic [1:0] OP_ONESHOT = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] limit;
  logic             limit_we;
  logic             tc_nxt;
`ifdef TFF_CTRL_ONESHOT_EN
  logic             done_nxt;
`endif
  logic             accept;
  logic             cmd_hit;
  logic             in_one;
  logic             counting;
  logic             at_term;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;

  assign cmd_ready = !rst && (state != ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);

`ifdef TFF_CTRL_ONESHOT_EN
  assign in_one  = (state == ST_ONE);
  assign cmd_hit = accept;
`else
  // Op 11 is still handshaken, but it must not pause a running count.
  assign in_one  = 1'b0;
  assign cmd_hit = accept && (cmd_op != OP_ONESHOT);
`endif

  assign counting = (state == ST_RUN) || in_one;
  assign at_term  = up_dn ? (q == limit) : (q == '0);

  // Ripple-AND toggle patterns for a binary increment (q) and decrement (qbar).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & qbar[i-1];
    end
  end

  // Select the toggle vector applied at the next edge.
  always_comb begin
    t_vec = '0;
    if (state == ST_LOAD) begin
      t_vec = q;
    end else if (counting && !cmd_hit) begin
      if (!at_term) begin
        t_vec = up_dn ? t_up : t_dn;
      end else if (!in_one) begin
        t_vec = up_dn ? q : (q ^ limit);
      end
    end
  end

  // Command decoding, terminal handling and pulse generation.
  always_comb begin
    state_nxt = state;
    limit_we  = 1'b0;
    tc_nxt    = 1'b0;
`ifdef TFF_CTRL_ONESHOT_EN
    done_nxt  = 1'b0;
`endif
    if (state == ST_LOAD) begin
      state_nxt = ST_IDLE;
    end else if (cmd_hit) begin
      case (cmd_op)
        OP_START: state_nxt = ST_RUN;
        OP_STOP:  state_nxt = ST_IDLE;
        OP_LOAD: begin
          state_nxt = ST_LOAD;
          limit_we  = 1'b1;
        end
`ifdef TFF_CTRL_ONESHOT_EN
        OP_ONESHOT: state_nxt = ST_ONE;
`endif
        default: state_nxt = state;
      endcase
    end else if (counting && at_term) begin
`ifdef TFF_CTRL_ONESHOT_EN
      if (in_one) begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end else begin
        tc_nxt = 1'b1;
      end
`else
      tc_nxt = 1'b1;
`endif
    end
  end

  // Toggle cells, controller state, limit and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      qbar  <= '1;
      limit <= '1;
      state <= ST_IDLE;
      tc    <= 1'b0;
    end else begin
      q     <= q ^ t_vec;
      qbar  <= ~(q ^ t_vec);
      state <= state_nxt;
      tc    <= tc_nxt;
      if (limit_we) begin
        limit <= cmd_data;
      end
    end
  end

`ifdef TFF_CTRL_ONESHOT_EN
  // One-shot completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= done_nxt;
    end
  end
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed testbench for tff_count_ctrl with WIDTH=4.
module tb_tff_count_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         up_dn;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic [W-1:0] t_vec;
  logic         busy;
  logic         tc;
  logic         done;

  int total = 0;
  int bad   = 0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .up_dn     (up_dn),
    .q         (q),
    .qbar      (qbar),
    .t_vec     (t_vec),
    .busy      (busy),
    .tc        (tc),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // qbar must mirror q on every cycle.
  always @(negedge clk) begin
    total++;
    if (qbar !== ~q) begin
      bad++;
      $display("FAIL qbar_compl: q=%b qbar=%b required qbar=%b", q, qbar, ~q);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL rst_q: got %b want 0000", q); end
    total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL rst_qbar: got %b want 1111", qbar); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    total++; if (busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_flags: busy=%b tc=%b done=%b want 000", busy, tc, done);
    end
    rst = 1'b0;
    step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", cmd_ready); end
  endtask

  task automatic test_count_up();
    issue(2'b10, 4'd5);
    total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL up_loading: ready=%b busy=%b want 0 1", cmd_ready, busy);
    end
    step();
    total++; if (q !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL up_loaded: q=%0d busy=%b ready=%b want 0 0 1", q, busy, cmd_ready);
    end
    up_dn = 1'b1;
    issue(2'b00, 4'd0);
    total++; if (q !== 4'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL up_start: q=%0d busy=%b want 0 1", q, busy);
    end
    for (int j = 1; j <= 5; j++) begin
      step();
      total++; if (q !== W'(j) || tc !== 1'b0) begin
        bad++; $display("FAIL up_count: q=%0d tc=%b want %0d 0", q, tc, j);
      end
    end
    step();
    total++; if (q !== 4'd0 || tc !== 1'b1) begin bad++; $display("FAIL up_wrap: q=%0d tc=%b want 0 1", q, tc); end
    step();
    total++; if (q !== 4'd1 || tc !== 1'b0) begin bad++; $display("FAIL up_after_wrap: q=%0d tc=%b want 1 0", q, tc); end
  endtask

  task automatic test_count_down();
    issue(2'b10, 4'd5);
    step();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL dn_cleared: q=%0d want 0", q); end
    up_dn = 1'b0;
    issue(2'b00, 4'd0);
    total++; if (q !== 4'd0) begin bad++; $display("FAIL dn_start: q=%0d want 0", q); end
    step();
    total++; if (q !== 4'd5 || tc !== 1'b1) begin bad++; $display("FAIL dn_wrap1: q=%0d tc=%b want 5 1", q, tc); end
    for (int v = 4; v >= 0; v--) begin
      step();
      total++; if (q !== W'(v) || tc !== 1'b0) begin
        bad++; $display("FAIL dn_count: q=%0d tc=%b want %0d 0", q, tc, v);
      end
    end
    step();
    total++; if (q !== 4'd5 || tc !== 1'b1) begin bad++; $display("FAIL dn_wrap2: q=%0d tc=%b want 5 1", q, tc); end
  endtask

  task automatic test_stop();
    step();
    step();
    total++; if (q !== 4'd3) begin bad++; $display("FAIL stop_pre: q=%0d want 3", q); end
    issue(2'b01, 4'd0);
    total++; if (q !== 4'd3 || busy !== 1'b0) begin bad++; $display("FAIL stop_accept: q=%0d busy=%b want 3 0", q, busy); end
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (q !== 4'd3 || busy !== 1'b0 || tc !== 1'b0) begin
        bad++; $display("FAIL stop_hold: q=%0d busy=%b tc=%b want 3 0 0", q, busy, tc);
      end
    end
    up_dn = 1'b1;
    issue(2'b00, 4'd0);
    total++; if (q !== 4'd3 || busy !== 1'b1) begin bad++; $display("FAIL restart_edge: q=%0d busy=%b want 3 1", q, busy); end
    step();
    total++; if (q !== 4'd4) begin bad++; $display("FAIL restart_count: q=%0d want 4", q); end
    up_dn = 1'b0;
    step();
    total++; if (q !== 4'd3) begin bad++; $display("FAIL dir_change: q=%0d want 3", q); end
    step();
    total++; if (q !== 4'd2) begin bad++; $display("FAIL dir_change2: q=%0d want 2", q); end
  endtask

  task automatic test_load_in_run();
    issue(2'b10, 4'd9);
    total++; if (cmd_ready !== 1'b0 || q !== 4'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL ldrun_loading: ready=%b q=%0d busy=%b want 0 2 1", cmd_ready, q, busy);
    end
    step();
    total++; if (q !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ldrun_idle: q=%0d busy=%b ready=%b want 0 0 1", q, busy, cmd_ready);
    end
    up_dn = 1'b1;
    issue(2'b00, 4'd0);
    for (int j = 1; j <= 9; j++) begin
      step();
      total++; if (q !== W'(j) || tc !== 1'b0) begin
        bad++; $display("FAIL ldrun_count: q=%0d tc=%b want %0d 0", q, tc, j);
      end
    end
    step();
    total++; if (q !== 4'd0 || tc !== 1'b1) begin bad++; $display("FAIL ldrun_wrap: q=%0d tc=%b want 0 1", q, tc); end
  endtask

  task automatic test_oneshot();
    issue(2'b10, 4'd3);
    step();
    up_dn = 1'b1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL os_ready: got %b want 1", cmd_ready); end
    issue(2'b11, 4'd0);
`ifdef TFF_CTRL_ONESHOT_EN
    total++; if (q !== 4'd0 || busy !== 1'b1) begin bad++; $display("FAIL os_start: q=%0d busy=%b want 0 1", q, busy); end
    for (int j = 1; j <= 3; j++) begin
      step();
      total++; if (q !== W'(j) || done !== 1'b0 || tc !== 1'b0) begin
        bad++; $display("FAIL os_count: q=%0d done=%b tc=%b want %0d 0 0", q, done, tc, j);
      end
    end
    step();
    total++; if (q !== 4'd3 || done !== 1'b1 || tc !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL os_done: q=%0d done=%b tc=%b busy=%b want 3 1 0 0", q, done, tc, busy);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (q !== 4'd3 || done !== 1'b0 || tc !== 1'b0) begin
        bad++; $display("FAIL os_hold: q=%0d done=%b tc=%b want 3 0 0", q, done, tc);
      end
    end
`else
    total++; if (q !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL os_noop: q=%0d busy=%b want 0 0", q, busy); end
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (q !== 4'd0 || done !== 1'b0 || tc !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL os_noop_hold: q=%0d done=%b tc=%b busy=%b want 0 0 0 0", q, done, tc, busy);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    issue(2'b10, 4'd10);
    step();
    up_dn = 1'b1;
    issue(2'b00, 4'd0);
    repeat (7) step();
    total++; if (q !== 4'd7) begin bad++; $display("FAIL mid_pre: q=%0d want 7", q); end
    rst = 1'b1;
    step();
    total++; if (q !== 4'd0 || qbar !== 4'b1111 || tc !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst: q=%b qbar=%b tc=%b done=%b busy=%b ready=%b want 0000 1111 0 0 0 0",
                      q, qbar, tc, done, busy, cmd_ready);
    end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
    step();
    total++; if (q !== 4'd0 || tc !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_quiet: q=%0d tc=%b done=%b want 0 0 0", q, tc, done);
    end
    issue(2'b00, 4'd0);
    for (int j = 1; j <= 15; j++) begin
      step();
      total++; if (q !== W'(j) || tc !== 1'b0) begin
        bad++; $display("FAIL mid_limit15: q=%0d tc=%b want %0d 0", q, tc, j);
      end
    end
    step();
    total++; if (q !== 4'd0 || tc !== 1'b1) begin bad++; $display("FAIL mid_wrap15: q=%0d tc=%b want 0 1", q, tc); end
  endtask

  task automatic test_limit_zero();
    issue(2'b10, 4'd0);
    step();
    up_dn = 1'b1;
    issue(2'b00, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (q !== 4'd0 || tc !== 1'b1) begin
        bad++; $display("FAIL lim0: q=%0d tc=%b want 0 1", q, tc);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    up_dn     = 1'b1;
    test_reset();
    test_count_up();
    test_count_down();
    test_stop();
    test_load_in_run();
    test_oneshot();
    test_reset_mid_run();
    test_limit_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Controller that sequences a bank of WIDTH toggle (T) flip-flop cells as a programmable modulo counter. Each cycle it computes a toggle-enable vector from current state, direction and a loaded limit, then applies it to the internal cell bank. Commands arrive over a valid/ready handshake from the local control logic. The block also produces terminal-count and completion pulses for downstream timing logic.

## Interface
- WIDTH, 8, number of toggle cells / counter width (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready at rising edge
- cmd_op  in  2  00 START, 01 STOP, 10 LOAD, 11 ONESHOT (see Configuration)
- cmd_data  in  WIDTH  limit value, used by LOAD only
- up_dn  in  1  1 = count up, 0 = count down; sampled every RUN cycle
- q  out  WIDTH  cell outputs
- qbar  out  WIDTH  complementary cell outputs, always ~q
- t_vec  out  WIDTH  toggle vector applied at the next edge (combinational, debug)
- busy  out  1  high in RUN, ONE and LOADING
- tc  out  1  one-cycle pulse, free-run wrap occurred on previous edge
- done  out  1  one-cycle pulse, one-shot completed on previous edge

## Operation
- Cell update per bit: q[i] <= q[i] ^ t_vec[i]; qbar[i] <= ~(q[i] ^ t_vec[i]). Cells are never written other than by toggling, except under reset.
- States: IDLE, RUN, ONE (one-shot run), LOADING. Register `limit` is WIDTH bits.
- Toggle vector in RUN/ONE:
  - up, q != limit: t_vec[i] = AND(q[i-1:0]), t_vec[0]=1
  - down, q != 0: t_vec[i] = AND(qbar[i-1:0]), t_vec[0]=1
  - up, q == limit (RUN): t_vec = q (wrap to 0), tc next cycle
  - down, q == 0 (RUN): t_vec = q ^ limit (wrap to limit), tc next cycle
- LOADING: t_vec = q (clears count). IDLE: t_vec = 0.
- cmd_ready = 1 in IDLE, RUN and ONE; 0 in LOADING and while rst is high.
- Transitions on accepted command:
  - IDLE: START→RUN; LOAD→LOADING (limit<=cmd_data same edge); STOP→IDLE (no-op); ONESHOT→ONE
  - RUN/ONE: STOP→IDLE; LOAD→LOADING (stop plus load); START or ONESHOT→switch to RUN or ONE respectively, no count lost
  - LOADING→IDLE unconditionally after one cycle
- On the edge that accepts a command in RUN/ONE, the command transition applies, and t_vec for that edge is 0 (no count).
- ONE: counts as RUN, but at terminal (up: q==limit, down: q==0) t_vec=0, state→IDLE, done pulses; tc not asserted.
- limit=0: up in RUN wraps every edge (q stays 0, tc every cycle).
- Count values above limit are unreachable, because LOAD clears q.

## Timing
- Reset values: q=0, qbar=all ones, limit=all ones, state IDLE, busy=0, tc=0, done=0; cmd_ready=0 during rst and 1 the cycle after.
- rst has priority over any command or count in the same cycle; reset mid-run aborts with no pulses.
- Command accepted at edge k → new state visible after k; first count at edge k+1.
- tc/done registered: high for exactly the cycle after the wrap/terminal edge.
- Changing up_dn between cycles takes effect on the next edge; no extra latency.
- LOAD: cmd_ready low for one cycle; q=0 and limit visible after the accepting edge+1.

## Configuration
- TFF_CTRL_ONESHOT_EN defined: ONESHOT op and state ONE are implemented and done is driven as specified.
- TFF_CTRL_ONESHOT_EN not defined: op 11 is accepted (ready high) with no effect, ONE state is absent, and done is tied to 0.

## Test plan
- Reset, WIDTH=4: q=0000, qbar=1111, cmd_ready=0 during rst; LOAD 4'd5, START, up_dn=1 → q counts 0..5, 0; tc high one cycle when q shows 0.
- Down count, limit=5: from q=0, START up_dn=0 → q=5,4,…,0,5; tc after each 0→5 wrap.
- STOP at q=3: q holds 3 for ≥10 cycles, busy=0; START → next edge q=4.
- LOAD issued in RUN at q=2 with cmd_data=9 → cmd_ready=0 one cycle, q=0, limit=9, state IDLE, busy=0 after.
- TFF_CTRL_ONESHOT_EN defined, limit=3, ONESHOT up → q=1,2,3, then holds 3; done pulses once; tc never asserted. Macro undefined: same op → q stays 0, done=0.
- rst asserted mid-RUN at q=7 → next cycle q=0, qbar=1111, limit=15, no tc or done; qbar==~q checked every cycle across all tests.
